// File: rtl/divider_arbiter_if.sv
// Signal bundle between the divider arbiter, its requesters and the shared divider.
// master = requesters plus divider (drive inputs), slave = the arbiter itself.
interface divider_arbiter_if #(
   parameter int nBit = 7,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req;
   logic [NREQ*nBit-1:0] req_A;
   logic [NREQ*nBit-1:0] req_B;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_valid;
   logic [nBit-1:0]      rsp_Q;
   logic [nBit-1:0]      rsp_R;
   logic                 rsp_dz;
   logic                 div_start;
   logic [nBit-1:0]      div_A;
   logic [nBit-1:0]      div_B;
   logic                 div_done;
   logic [nBit-1:0]      div_Q;
   logic [nBit-1:0]      div_R;

   modport master (
      output req, req_A, req_B, div_done, div_Q, div_R,
      input  gnt, rsp_valid, rsp_Q, rsp_R, rsp_dz, div_start, div_A, div_B
   );

   modport slave (
      input  req, req_A, req_B, div_done, div_Q, div_R,
      output gnt, rsp_valid, rsp_Q, rsp_R, rsp_dz, div_start, div_A, div_B
   );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider between NREQ requesters.
// Optional DIVARB_ZERO_BYPASS_EN: answer B=0 jobs locally without launching the divider.
//
// state | meaning
// IDLE  | waiting for any req; winner captured on the leaving edge
// ISSUE | one cycle: gnt[owner] and div_start pulse
// WAIT  | operands held on div_A/div_B until div_done
// RESP  | one cycle: rsp_valid[owner] with rsp_Q/rsp_R
module divider_arbiter #(
   parameter int nBit = 7,
   parameter int NREQ = 4
) (
   input logic             clk,
   input logic             reset,
   divider_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, owner_q;
   logic [PW-1:0]   win, idx;
   logic            found;
   logic [nBit-1:0] win_a, win_b;
   logic [NREQ-1:0] gnt_q, rsp_valid_q;
   logic            div_start_q;
   logic [nBit-1:0] div_a_q, div_b_q, rsp_q_q, rsp_r_q;

   // First set request bit at or after ptr, wrapping modulo NREQ.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(ptr_q) + i) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            win_a = bus.req_A[i*nBit +: nBit];
            win_b = bus.req_B[i*nBit +: nBit];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = ISSUE;
`ifdef DIVARB_ZERO_BYPASS_EN
         ISSUE:   state_d = (div_b_q == '0) ? RESP : WAIT;
`else
         ISSUE:   state_d = WAIT;
`endif
         WAIT:    if (bus.div_done) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         div_start_q <= 1'b0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         rsp_q_q     <= '0;
         rsp_r_q     <= '0;
      end else begin
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         div_start_q <= 1'b0;
         case (state_q)
            IDLE: if (found) begin
               div_a_q <= win_a;
               div_b_q <= win_b;
               owner_q <= win;
               ptr_q   <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
               gnt_q   <= NREQ'(1) << win;
`ifdef DIVARB_ZERO_BYPASS_EN
               div_start_q <= (win_b != '0);
`else
               div_start_q <= 1'b1;
`endif
            end
`ifdef DIVARB_ZERO_BYPASS_EN
            ISSUE: if (div_b_q == '0) begin
               rsp_q_q <= '1;
               rsp_r_q <= div_a_q;
            end
`endif
            WAIT: if (bus.div_done) begin
               rsp_q_q <= bus.div_Q;
               rsp_r_q <= bus.div_R;
            end
            default: ;
         endcase
         if (state_d == RESP) rsp_valid_q <= NREQ'(1) << owner_q;
      end
   end

`ifdef DIVARB_ZERO_BYPASS_EN
   logic rsp_dz_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  rsp_dz_q <= 1'b0;
      else if (state_q == WAIT && bus.div_done)    rsp_dz_q <= 1'b0;
      else if (state_q == ISSUE && div_b_q == '0)  rsp_dz_q <= 1'b1;
   end

   assign bus.rsp_dz = rsp_dz_q;
`else
   assign bus.rsp_dz = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_Q     = rsp_q_q;
   assign bus.rsp_R     = rsp_r_q;
   assign bus.div_start = div_start_q;
   assign bus.div_A     = div_a_q;
   assign bus.div_B     = div_b_q;
endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one sequential divider (A/B in, Q/R out, start/done handshake) between NREQ independent requesters. Grants round-robin, launches the divider with the winner's operands, waits for completion, and returns the quotient and remainder to that requester only. Sits between client blocks and the divider top level; the divider and this arbiter share `clk` and `reset`.

## Interface
- nBit, 7, operand/result width
- NREQ, 4, number of requesters (legal range 2..8)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_A  in  NREQ*nBit  dividends; requester i at bits [i*nBit +: nBit]
- req_B  in  NREQ*nBit  divisors; same packing as req_A
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of requester i captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; result for requester i
- rsp_Q  out  nBit  quotient, valid while any rsp_valid bit is high
- rsp_R  out  nBit  remainder, valid while any rsp_valid bit is high
- rsp_dz  out  1  divide-by-zero flag, valid with rsp_valid
- div_start  out  1  one-cycle launch pulse to the divider
- div_A  out  nBit  dividend to the divider, held from div_start until div_done
- div_B  out  nBit  divisor to the divider, same hold rule
- div_done  in  1  one-cycle completion pulse from the divider
- div_Q  in  nBit  divider quotient, sampled on div_done
- div_R  in  nBit  divider remainder, sampled on div_done

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE, round-robin pointer ptr=0, and every output 0 (gnt, rsp_valid, rsp_Q, rsp_R, rsp_dz, div_start, div_A, div_B). Reset takes effect immediately, including mid-job. The in-flight result is discarded.
- IDLE, req≠0: the winner is the first set bit searching ptr, ptr+1, … modulo NREQ. On the clock edge:
  - capture the winner's A and B into div_A/div_B;
  - record the winner index as owner;
  - set ptr = (owner+1) mod NREQ;
  - go to ISSUE.
- IDLE, req=0: stay in IDLE.
- ISSUE: lasts exactly one cycle, with gnt[owner]=1 and div_start=1. Next state is WAIT.
- WAIT: hold div_A/div_B. On div_done=1, capture div_Q/div_R into rsp_Q/rsp_R, clear rsp_dz, and go to RESP.
- RESP: lasts exactly one cycle, with rsp_valid[owner]=1. Next state is IDLE. rsp_Q/rsp_R/rsp_dz hold their values until the next capture.
- div_done is ignored in IDLE, ISSUE and RESP.
- Requesters hold req and operands until they see gnt. Dropping req before gnt withdraws the request with no side effect. req still high after gnt is treated as a new request.
- req changes outside IDLE do not affect the current job.

## Timing
- req sampled high at edge k (IDLE): gnt and div_start are high during cycle k→k+1.
- div_done sampled at edge m: rsp_valid is high during cycle m→m+1.
- IDLE is re-entered at edge m+1. The earliest next gnt is in cycle m+2→m+3.
- Arbiter overhead per job: 3 cycles plus the divider latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DIVARB_ZERO_BYPASS_EN` defined:
  - In ISSUE, if the captured B is 0, div_start stays 0. gnt still pulses as normal.
  - Next state is RESP, with rsp_Q = all ones, rsp_R = captured A, rsp_dz = 1.
  - The divider is never launched for a zero divisor.
- `DIVARB_ZERO_BYPASS_EN` undefined:
  - B=0 is launched to the divider like any other job.
  - rsp_dz is constant 0.

## Test plan
All scenarios use nBit=7, NREQ=4, and a divider model with 8-cycle latency.
- Single request: req=0001, A=100, B=7.
  - Required: gnt=0001 for one cycle, coincident with div_start.
  - Required: div_A=100 and div_B=7 held until div_done.
  - Required: rsp_valid=0001 one cycle after div_done, with rsp_Q=14, rsp_R=2, rsp_dz=0.
- Contention from reset: req=1111 held continuously.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Then req=1001 after the grant to 3: next grant is 0001, then 1000.
- Zero divisor: req=0100, A=45, B=0.
  - With the macro: no div_start; rsp_valid=0100 in the cycle after gnt, with rsp_Q=127, rsp_R=45, rsp_dz=1.
  - Without the macro: div_start pulses with div_B=0.
- Reset during WAIT: assert reset low.
  - Required: all outputs 0 immediately, and a later div_done is ignored.
  - After release with req=0110: first grant is 0010 (ptr back to 0).
- Stray and withdrawn events: a div_done pulse while in IDLE, and a one-cycle req pulse that drops before any gnt could occur in a busy phase.
  - Required: no rsp_valid, no gnt, and the pointer is unchanged.
- Small dividend: A=5, B=9 on requester 3.
  - Required: rsp_valid=1000, rsp_Q=0, rsp_R=5.
